// File: rtl/writeback_buffer.sv
// Write-back result queue: accepts memory-stage results, retires one register write per cycle
// and lets decode forward values that are still queued or in the output register.
module writeback_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RegWriteM,
  input  logic                     MemtoRegM,
  input  logic [DATA_W-1:0]        ALUOutM,
  input  logic [DATA_W-1:0]        ReadDataM,
  input  logic [ADDR_W-1:0]        WA3M,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WA3W,
  output logic [DATA_W-1:0]        ResultW,
  input  logic [ADDR_W-1:0]        RA1,
  input  logic [ADDR_W-1:0]        RA2,
  output logic                     Fwd1Hit,
  output logic [DATA_W-1:0]        Fwd1Data,
  output logic                     Fwd2Hit,
  output logic [DATA_W-1:0]        Fwd2Data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // r15 reads come from PC+8 in decode, so it is never written or forwarded here.
  localparam logic [ADDR_W-1:0] PcReg = '1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wa3w_q, wa3w_d;
  logic [DATA_W-1:0] resultw_q, resultw_d;

  logic              accept, push, pop;
  logic [DATA_W-1:0] in_data;

  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && RegWriteM && (WA3M != PcReg);
  assign pop      = (count_q != '0) && !wb_stall;
  assign in_data  = MemtoRegM ? ReadDataM : ALUOutM;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    wa3w_d     = wa3w_q;
    resultw_d  = resultw_q;
    if (pop) begin
      regwrite_d = 1'b1;
      wa3w_d     = addr_mem[rd_ptr_q];
      resultw_d  = data_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wa3w_q     <= '0;
      resultw_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wa3w_q     <= wa3w_d;
      resultw_q  <= resultw_d;
    end
  end

  // Storage needs no reset: entries outside [rd_ptr, rd_ptr+count) are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= WA3M;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  assign RegWrite = regwrite_q;
  assign WA3W     = wa3w_q;
  assign ResultW  = resultw_q;
  assign count    = count_q;

  logic [ADDR_W-1:0] fwd_ra   [2];
  logic              fwd_hit  [2];
  logic [DATA_W-1:0] fwd_data [2];
  logic [PW-1:0]     fwd_idx;

  assign fwd_ra[0] = RA1;
  assign fwd_ra[1] = RA2;

  // Walk oldest to newest so the youngest matching entry wins; output register is lowest.
  always_comb begin
    fwd_idx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      if (regwrite_q && (wa3w_q == fwd_ra[p])) begin
        fwd_hit[p]  = 1'b1;
        fwd_data[p] = resultw_q;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        fwd_idx = rd_ptr_q + PW'(k);
        if ((CW'(k) < count_q) && (addr_mem[fwd_idx] == fwd_ra[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = data_mem[fwd_idx];
        end
      end
      if (fwd_ra[p] == PcReg) begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
      end
    end
  end

  assign Fwd1Hit  = fwd_hit[0];
  assign Fwd1Data = fwd_data[0];
  assign Fwd2Hit  = fwd_hit[1];
  assign Fwd2Data = fwd_data[1];

  a_count_bound : assert property (@(posedge clk) disable iff (!reset) count_q <= CW'(DEPTH));
  a_no_full_push : assert property (@(posedge clk) disable iff (!reset)
                                    (count_q == CW'(DEPTH)) |-> !accept);

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: latency, load select, full/stall, forwarding, drops, reset.
module tb_writeback_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ALUOutM, ReadDataM;
  logic [3:0]  WA3M;
  logic        wb_stall;
  logic        RegWrite;
  logic [3:0]  WA3W;
  logic [31:0] ResultW;
  logic [3:0]  RA1, RA2;
  logic        Fwd1Hit, Fwd2Hit;
  logic [31:0] Fwd1Data, Fwd2Data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_buffer #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .WA3M      (WA3M),
    .wb_stall  (wb_stall),
    .RegWrite  (RegWrite),
    .WA3W      (WA3W),
    .ResultW   (ResultW),
    .RA1       (RA1),
    .RA2       (RA2),
    .Fwd1Hit   (Fwd1Hit),
    .Fwd1Data  (Fwd1Data),
    .Fwd2Hit   (Fwd2Hit),
    .Fwd2Data  (Fwd2Data),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [3:0] wa,
                       input logic [31:0] alu, input logic [31:0] rd);
    in_valid  = v;
    RegWriteM = rw;
    MemtoRegM = m2r;
    WA3M      = wa;
    ALUOutM   = alu;
    ReadDataM = rd;
  endtask

  initial begin
    reset    = 1'b0;
    wb_stall = 1'b0;
    RA1      = 4'd0;
    RA2      = 4'd0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_wa3w", 64'(WA3W), 64'd0);
    check("rst_resultw", 64'(ResultW), 64'd0);
    reset = 1'b1;
    tick();

    // ALU write: accepted at edge 1, retired at edge 2
    drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h0000_1234, 32'hFFFF_FFFF);
    check("alu_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("alu_count1", 64'(count), 64'd1);
    check("alu_rw_early", 64'(RegWrite), 64'd0);
    tick();
    check("alu_rw", 64'(RegWrite), 64'd1);
    check("alu_wa3w", 64'(WA3W), 64'd3);
    check("alu_result", 64'(ResultW), 64'h0000_1234);
    check("alu_count0", 64'(count), 64'd0);
    tick();
    check("alu_rw_drop", 64'(RegWrite), 64'd0);
    check("alu_wa3w_hold", 64'(WA3W), 64'd3);
    check("alu_result_hold", 64'(ResultW), 64'h0000_1234);

    // Load select
    drive(1'b1, 1'b1, 1'b1, 4'd4, 32'h0000_0001, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("ld_rw", 64'(RegWrite), 64'd1);
    check("ld_wa3w", 64'(WA3W), 64'd4);
    check("ld_result", 64'(ResultW), 64'hDEAD_BEEF);

    // Full under stall: four writes fill, fifth held
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'(i + 1), 32'h100 + 32'(i), 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h104, 32'd0);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    tick();
    check("full_hold_count", 64'(count), 64'd4);
    check("full_hold_rw", 64'(RegWrite), 64'd0);
    wb_stall = 1'b0;
    #1;
    check("full_ready_unstall", 64'(in_ready), 64'd0);
    tick();
    check("drain0_count", 64'(count), 64'd3);
    check("drain0_ready", 64'(in_ready), 64'd1);
    check("drain0_wa3w", 64'(WA3W), 64'd1);
    check("drain0_result", 64'(ResultW), 64'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("drain1_count", 64'(count), 64'd3);
    check("drain1_result", 64'(ResultW), 64'h101);
    for (int i = 2; i < 5; i++) begin
      tick();
      check("drain_rw", 64'(RegWrite), 64'd1);
      check("drain_wa3w", 64'(WA3W), 64'(i + 1));
      check("drain_result", 64'(ResultW), 64'h100 + 64'(i));
      check("drain_count", 64'(count), 64'(4 - i));
    end
    tick();
    check("drain_idle_rw", 64'(RegWrite), 64'd0);

    // Forwarding: newest queued r5 wins
    wb_stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h11, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h22, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    RA1 = 4'd5;
    RA2 = 4'd6;
    #1;
    check("fwd_count", 64'(count), 64'd2);
    check("fwd1_hit", 64'(Fwd1Hit), 64'd1);
    check("fwd1_data", 64'(Fwd1Data), 64'h22);
    check("fwd2_hit", 64'(Fwd2Hit), 64'd0);
    check("fwd2_data", 64'(Fwd2Data), 64'd0);
    wb_stall = 1'b0;
    tick();
    wb_stall = 1'b1;
    #1;
    check("fwd_ret_rw", 64'(RegWrite), 64'd1);
    check("fwd_ret_result", 64'(ResultW), 64'h11);
    check("fwd_ret_data", 64'(Fwd1Data), 64'h22);
    wb_stall = 1'b0;
    tick();
    check("fwd_outreg_hit", 64'(Fwd1Hit), 64'd1);
    check("fwd_outreg_data", 64'(Fwd1Data), 64'h22);
    tick();
    check("fwd_gone_hit", 64'(Fwd1Hit), 64'd0);

    // Drops: RegWriteM=0 and r15 complete the handshake but never queue
    drive(1'b1, 1'b0, 1'b0, 4'd2, 32'h55, 32'd0);
    #1;
    check("drop_ready0", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h66, 32'd0);
    check("drop_count0", 64'(count), 64'd0);
    check("drop_ready1", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("drop_count1", 64'(count), 64'd0);
    check("drop_rw0", 64'(RegWrite), 64'd0);
    RA1 = 4'hF;
    #1;
    check("drop_r15_hit", 64'(Fwd1Hit), 64'd0);
    tick();
    check("drop_rw1", 64'(RegWrite), 64'd0);

    // Reset mid-operation with two entries queued
    wb_stall = 1'b1;
    RA1 = 4'd7;
    drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h77, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("pre_rst_count", 64'(count), 64'd2);
    check("pre_rst_hit", 64'(Fwd1Hit), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_rw", 64'(RegWrite), 64'd0);
    check("mid_rst_wa3w", 64'(WA3W), 64'd0);
    check("mid_rst_result", 64'(ResultW), 64'd0);
    check("mid_rst_hit", 64'(Fwd1Hit), 64'd0);
    #1;
    reset    = 1'b1;
    wb_stall = 1'b0;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    tick();
    check("post_rst_rw", 64'(RegWrite), 64'd0);
    check("post_rst_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
